// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single-ported memory.
// Data has priority, but fetch is forced through once it has waited MAX_WAIT cycles.
module mem_arbiter #(
  parameter int unsigned MAX_WAIT       = 4,
  parameter bit          WORD_ALIGN_CHK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ready,
  output logic [31:0] dm_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        err_align
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] MAX_WAIT_C = CW'(MAX_WAIT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACC_I  = 3'd1,
    ACC_D  = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_ready_q, if_ready_d;
  logic          dm_ready_q, dm_ready_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          err_q, err_d;
  logic          dm_req;

  assign dm_req = dm_read | dm_write;

  // Arbitration, access sequencing and fetch starvation counter
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    err_d       = err_q;

    if (if_req && (state_q != ACC_I) && (state_q != RESP_I) && (wait_q < MAX_WAIT_C)) begin
      wait_d = wait_q + CW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (if_req && (!dm_req || (wait_q == MAX_WAIT_C))) begin
          state_d    = ACC_I;
          wait_d     = '0;
          mem_read_d = 1'b1;
          mem_addr_d = if_addr;
          if (WORD_ALIGN_CHK && (if_addr[1:0] != 2'b00)) err_d = 1'b1;
        end else if (dm_req) begin
          // Simultaneous read+write performs the write only
          state_d     = ACC_D;
          mem_write_d = dm_write;
          mem_read_d  = ~dm_write;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_write ? dm_wdata : '0;
          if (WORD_ALIGN_CHK && (dm_addr[1:0] != 2'b00)) err_d = 1'b1;
        end
      end
      ACC_I: begin
        if_rdata_d = mem_rdata;
        if_ready_d = 1'b1;
        state_d    = RESP_I;
      end
      ACC_D: begin
        if (mem_read_q) dm_rdata_d = mem_rdata;
        dm_ready_d = 1'b1;
        state_d    = RESP_D;
      end
      RESP_I, RESP_D: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      err_q       <= err_d;
    end
  end

  // Reset during a write access must keep the memory from committing
  assign mem_write = mem_write_q & ~rst;
  assign mem_read  = mem_read_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign err_align = err_q;
  assign stall     = (if_req & ~if_ready_q) | (dm_req & ~dm_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences,
// and a randomized phase checked against a transaction-level shadow memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_read, dm_write;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_ready, dm_ready, mem_read, mem_write, stall, err_align;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem    [64];
  logic [31:0] shadow [64];
  int n_chk = 0;
  int n_pass = 0;

  mem_arbiter #(.MAX_WAIT(4), .WORD_ALIGN_CHK(1'b1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall(stall), .err_align(err_align)
  );

  always #5 clk = ~clk;

  // Shared memory: combinational read, write commits on posedge
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] = mem_wdata;

  typedef struct {
    bit          ifr;
    logic [31:0] ia;
    bit          rd, wr;
    logic [31:0] da, wd;
    bit          e_rd, e_wr;
    logic [31:0] e_addr, e_wdata;
    bit          e_ifrdy, e_dmrdy;
    logic [31:0] e_rdata;
    bit          e_err;
    int          e_idx;
    logic [31:0] e_mem;
  } vec_t;

  vec_t vecs[7];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
  endtask

  task automatic drive(input bit ifr, input logic [31:0] ia, input bit rd, input bit wr,
                       input logic [31:0] da, input logic [31:0] wd);
    if_req = ifr; if_addr = ia; dm_read = rd; dm_write = wr; dm_addr = da; dm_wdata = wd;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic mem_init_fixed;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[2] = 32'h0000_1234;
  endtask

  // Issue one request and wait (bounded) for its ready pulse
  task automatic do_req(input bit ifr, input logic [31:0] ia, input bit rd, input bit wr,
                        input logic [31:0] da, input logic [31:0] wd, output logic [31:0] rdata);
    bit got = 0;
    drive(ifr, ia, rd, wr, da, wd);
    for (int k = 0; k < 10 && !got; k++) begin
      tick;
      if (ifr ? if_ready : dm_ready) got = 1;
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("req_done", 32'(got), 32'd1);
    rdata = ifr ? if_rdata : dm_rdata;
  endtask

  initial begin
    logic [31:0] r;
    byte         g [6];
    int          ng;
    string       exp_order;
    bit          ip, dp, drd, dwr;
    logic [31:0] ia, da, dwd, last_dm;
    int          iage, dage, op;
    bit          any_rdy;

    //               ifr ia       rd wr da        wd          e_rd e_wr e_addr    e_wdata    ifrdy dmrdy e_rdata       err idx mem
    vecs[0] = '{1, 32'h08, 0, 0, 32'h00, 32'h0,   1, 0, 32'h08, 32'h0,    1, 0, 32'h0000_1234, 0, -1, 32'h0};
    vecs[1] = '{0, 32'h00, 1, 0, 32'h0C, 32'h0,   1, 0, 32'h0C, 32'h0,    0, 1, 32'hA000_0003, 0, -1, 32'h0};
    vecs[2] = '{0, 32'h00, 0, 1, 32'h10, 32'hCAFE, 0, 1, 32'h10, 32'hCAFE, 0, 1, 32'h0,         0,  4, 32'hCAFE};
    vecs[3] = '{0, 32'h00, 1, 1, 32'h04, 32'h55,  0, 1, 32'h04, 32'h55,   0, 1, 32'h0,         0,  1, 32'h55};
    vecs[4] = '{1, 32'h40, 1, 0, 32'h20, 32'h0,   1, 0, 32'h20, 32'h0,    0, 1, 32'hA000_0008, 0, -1, 32'h0};
    vecs[5] = '{1, 32'h06, 0, 0, 32'h00, 32'h0,   1, 0, 32'h06, 32'h0,    1, 0, 32'hA000_0001, 1, -1, 32'h0};
    vecs[6] = '{0, 32'h00, 1, 0, 32'h22, 32'h0,   1, 0, 32'h22, 32'h0,    0, 1, 32'hA000_0008, 1, -1, 32'h0};

    // Reset state
    do_reset;
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_ready", 32'(if_ready), 0);
    chk("rst_dm_ready", 32'(dm_ready), 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_err", 32'(err_align), 0);
    chk("rst_stall", 32'(stall), 0);

    // Vector table: request in cycle N, access at N+1 (request dropped), ready at N+2
    for (int i = 0; i < 7; i++) begin
      do_reset;
      mem_init_fixed;
      drive(vecs[i].ifr, vecs[i].ia, vecs[i].rd, vecs[i].wr, vecs[i].da, vecs[i].wd);
      tick;
      chk($sformatf("v%0d_mem_read", i), 32'(mem_read), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d_mem_write", i), 32'(mem_write), 32'(vecs[i].e_wr));
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
      if (vecs[i].e_wr) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      drive(0, 0, 0, 0, 0, 0);
      tick;
      chk($sformatf("v%0d_if_ready", i), 32'(if_ready), 32'(vecs[i].e_ifrdy));
      chk($sformatf("v%0d_dm_ready", i), 32'(dm_ready), 32'(vecs[i].e_dmrdy));
      chk($sformatf("v%0d_rdata", i), vecs[i].e_ifrdy ? if_rdata : dm_rdata, vecs[i].e_rdata);
      chk($sformatf("v%0d_err", i), 32'(err_align), 32'(vecs[i].e_err));
      chk($sformatf("v%0d_idle_mem_read", i), 32'(mem_read), 0);
      if (vecs[i].e_idx >= 0) chk($sformatf("v%0d_mem_word", i), mem[vecs[i].e_idx], vecs[i].e_mem);
    end

    // Write then read back the same word
    do_reset;
    mem_init_fixed;
    do_req(0, 0, 0, 1, 32'h10, 32'hCAFE, r);
    do_req(0, 0, 1, 0, 32'h10, 32'h0, r);
    chk("wr_then_rd", r, 32'hCAFE);

    // Both ports held: grant order must be data, data, fetch, repeating
    do_reset;
    mem_init_fixed;
    drive(1, 32'h40, 1, 0, 32'h80, 0);
    ng = 0;
    for (int k = 0; k < 18; k++) begin
      tick;
      if (mem_read && ng < 6) begin
        g[ng] = (mem_addr == 32'h40) ? 8'h49 : 8'h44;
        ng++;
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("arb_grant_count", 32'(ng), 32'd6);
    exp_order = "DDIDDI";
    for (int k = 0; k < 6 && k < ng; k++) chk($sformatf("arb_grant%0d", k), 32'(g[k]), 32'(exp_order[k]));

    // Alignment error is sticky until reset
    do_reset;
    mem_init_fixed;
    do_req(1, 32'h06, 0, 0, 0, 0, r);
    chk("err_set", 32'(err_align), 1);
    do_req(0, 0, 1, 0, 32'h00, 0, r);
    chk("err_sticky", 32'(err_align), 1);
    do_reset;
    chk("err_cleared", 32'(err_align), 0);

    // Reset during a write access aborts it
    mem_init_fixed;
    drive(0, 0, 0, 1, 32'h30, 32'hDEAD);
    tick;
    chk("abort_in_acc", 32'(mem_write), 1);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("abort_wr_gated", 32'(mem_write), 0);
    tick;
    chk("abort_dm_ready", 32'(dm_ready), 0);
    chk("abort_mem_write", 32'(mem_write), 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_mem_wdata", mem_wdata, 0);
    chk("abort_word", mem[12], 32'hA000_000C);
    rst = 1'b0;
    any_rdy = 0;
    for (int k = 0; k < 4; k++) begin
      tick;
      any_rdy |= dm_ready | if_ready;
    end
    chk("abort_no_ready", 32'(any_rdy), 0);

    // Randomized traffic checked against a shadow memory, ordered by completion
    do_reset;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      shadow[i] = mem[i];
    end
    ip = 0; dp = 0; drd = 0; dwr = 0; ia = 0; da = 0; dwd = 0;
    last_dm = 0; iage = 0; dage = 0;
    for (int c = 0; c < 600; c++) begin
      if (!ip && $urandom_range(0, 2) != 0) begin
        ip = 1; iage = 0;
        ia = 32'($urandom_range(0, 63)) << 2;
      end
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp = 1; dage = 0;
        op = $urandom_range(0, 3);
        drd = (op != 1);
        dwr = (op == 1) || (op == 2);
        da = 32'($urandom_range(0, 63)) << 2;
        dwd = $urandom;
      end
      drive(ip, ia, dp && drd, dp && dwr, da, dwd);
      tick;
      chk("rnd_stall", 32'(stall), 32'((ip && !if_ready) || (dp && !dm_ready)));
      chk("rnd_excl", 32'(mem_read && mem_write), 0);
      if (if_ready) begin
        chk("rnd_if_pending", 32'(ip), 1);
        chk("rnd_if_rdata", if_rdata, shadow[ia[7:2]]);
        ip = 0;
      end
      if (dm_ready) begin
        chk("rnd_dm_pending", 32'(dp), 1);
        if (dwr) begin
          shadow[da[7:2]] = dwd;
          chk("rnd_dm_rdata_kept", dm_rdata, last_dm);
        end else begin
          chk("rnd_dm_rdata", dm_rdata, shadow[da[7:2]]);
          last_dm = shadow[da[7:2]];
        end
        dp = 0;
      end
      if (ip) iage++;
      if (dp) dage++;
      if (iage > 12 || dage > 12) begin
        chk("rnd_timeout", 32'(iage > 12 || dage > 12), 0);
        break;
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) tick;
    chk("rnd_no_err", 32'(err_align), 0);
    for (int i = 0; i < 64; i++) chk($sformatf("rnd_mem%0d", i), mem[i], shadow[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MAX_WAIT, default 4, the number of waiting cycles after which fetch overrides data priority (legal 1..15).
REQ-002 Parameter: WORD_ALIGN_CHK, default 1; when 1, misalignment checking is enabled.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 if_req  input  1  instruction-fetch read request, level, held until if_ready.
REQ-006 if_addr  input  32  fetch byte address.
REQ-007 if_ready  output  1  one-cycle pulse; if_rdata is valid in the same cycle.
REQ-008 if_rdata  output  32  fetched word, registered.
REQ-009 dm_read  input  1  data read request, level, held until dm_ready.
REQ-010 dm_write  input  1  data write request, level, held until dm_ready.
REQ-011 dm_addr  input  32  data byte address.
REQ-012 dm_wdata  input  32  write data.
REQ-013 dm_ready  output  1  one-cycle completion pulse for a read or write.
REQ-014 dm_rdata  output  32  data read word, registered.
REQ-015 mem_read  output  1  to shared memory read enable.
REQ-016 mem_write  output  1  to shared memory write enable.
REQ-017 mem_addr  output  32  to shared memory address.
REQ-018 mem_wdata  output  32  to shared memory write data.
REQ-019 mem_rdata  input  32  from shared memory, combinational read data.
REQ-020 stall  output  1  high while any request is pending and its ready is not asserted.
REQ-021 err_align  output  1  sticky; set when a granted address has address[1:0] != 0.

Function
REQ-022 FSM states:
- IDLE: arbitrate.
- ACC_I / ACC_D: drive memory for one cycle.
- RESP_I / RESP_D: pulse ready.
REQ-023 In IDLE with any request, the arbiter latches the winner's address, data and operation, and moves to ACC_I or ACC_D.
REQ-024 Default priority is data over fetch.
REQ-025 Fetch wins when wait_cnt == MAX_WAIT.
REQ-026 wait_cnt (4 bits) increments on each cycle that if_req=1 and the FSM is not in ACC_I/RESP_I; it saturates at MAX_WAIT and clears when fetch is granted.
REQ-027 In ACC_I: mem_read=1, mem_addr=latched if_addr; mem_rdata is captured into if_rdata at the end of the cycle.
REQ-028 In ACC_D read: mem_read=1, mem_addr=latched dm_addr; mem_rdata is captured into dm_rdata at the end of the cycle.
REQ-029 In ACC_D write: mem_write=1, mem_addr=latched dm_addr, mem_wdata=latched dm_wdata; the memory commits on the posedge ending ACC_D.
REQ-030 If dm_read and dm_write are both 1 at grant, the arbiter performs the write only; dm_rdata is unchanged.
REQ-031 In RESP_I/RESP_D, the arbiter asserts if_ready/dm_ready for exactly one cycle, then returns to IDLE.
REQ-032 Latency is request-seen cycle N to ready at cycle N+2; throughput is one access per 3 cycles per port.
REQ-033 Outside ACC states: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-034 if_rdata and dm_rdata hold their last value until overwritten.
REQ-035 A request deasserted before its ready is not tracked: the latched access still completes and pulses ready.
REQ-036 A request still high in the cycle after ready is treated as a new request.
REQ-037 stall = (if_req & ~if_ready) | ((dm_read|dm_write) & ~dm_ready); it is combinational.
REQ-038 When WORD_ALIGN_CHK=1 and the granted address has [1:0] != 0, err_align sets at the ACC cycle; the access still proceeds using the address as given.
REQ-039 Only one of mem_read and mem_write is ever high in a cycle.

Reset
REQ-040 rst=1 at posedge gives:
- state=IDLE, wait_cnt=0, if_rdata=0, dm_rdata=0;
- if_ready=0, dm_ready=0, err_align=0;
- all mem_* outputs 0.
REQ-041 rst asserted mid-access (ACC_D write) aborts the access: no ready pulse is issued, and mem_write is 0 from the reset cycle onward.
REQ-042 Requests present during rst are ignored; arbitration begins in the first cycle after rst=0.

Verification
REQ-043 if_req=1, if_addr=0x8, mem word[2]=0x1234 -> mem_read=1, mem_addr=0x8 at cycle+1; if_ready=1, if_rdata=0x1234 at cycle+2.
REQ-044 dm_write=1, dm_addr=0x10, dm_wdata=0xCAFE, then dm_read at 0x10 -> dm_ready after write; the read returns dm_rdata=0xCAFE.
REQ-045 if_req and dm_read both held continuously, MAX_WAIT=4 -> data is served first, and fetch is granted no later than its wait_cnt reaching 4; no grant is issued twice in a row to data while wait_cnt=4.
REQ-046 dm_read=dm_write=1, dm_addr=0x4, dm_wdata=0x55 -> only mem_write pulses; word[1]=0x55; dm_rdata is unchanged.
REQ-047 if_addr=0x6 -> err_align=1 and remains 1 until rst.
REQ-048 rst pulsed during ACC_D write -> no dm_ready, all outputs 0 the next cycle, and the target word is unchanged.
